// File: rtl/game_pkg.sv
// Shared types and constants for the turn-based game controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    WIN
  } game_state_t;

  localparam int DICE_MIN = 1;
  localparam int DICE_MAX = 6;
  localparam int POS_W    = 10;

  // A roll is usable only when it is a real die face.
  function automatic logic is_legal_dice(input logic [2:0] value);
    return (value >= 3'(DICE_MIN)) && (value <= 3'(DICE_MAX));
  endfunction

endpackage

// File: rtl/pos_step_calc.sv
// Combinational position step: advances cur_x by dice*STEP_PX and clamps at FINISH_X.
module pos_step_calc
  import game_pkg::*;
#(
  parameter int STEP_PX  = 40,
  parameter int FINISH_X = 560
) (
  input  logic [POS_W-1:0] cur_x,
  input  logic [2:0]       dice_value,
  output logic [POS_W-1:0] next_x,
  output logic             reached_finish
);

  // One extra bit keeps the raw sum from wrapping before it is clamped.
  localparam logic [POS_W:0]   FINISH_EXT = (POS_W+1)'(FINISH_X);
  localparam logic [POS_W-1:0] FINISH_POS = POS_W'(FINISH_X);

  logic [POS_W:0] raw_sum;

  // Compute the unclamped target, then saturate it at the finish line.
  always_comb begin
    raw_sum        = {1'b0, cur_x} + ((POS_W+1)'(dice_value) * (POS_W+1)'(STEP_PX));
    next_x         = raw_sum[POS_W-1:0];
    reached_finish = 1'b0;
    if (raw_sum >= FINISH_EXT) begin
      next_x         = FINISH_POS;
      reached_finish = 1'b1;
    end
  end

endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencer between dice recognition and the UI renderer.
module game_turn_controller
  import game_pkg::*;
#(
  parameter int START_X      = 40,
  parameter int STEP_PX      = 40,
  parameter int FINISH_X     = 560,
  parameter int DONE_TIMEOUT = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dice_valid,
  input  logic [2:0]       dice_value,
  input  logic             game_restart,
  input  logic             turn_done,
  output logic             dice_ready,
  output logic [POS_W-1:0] player1_pos_x,
  output logic [POS_W-1:0] player2_pos_x,
  output logic             pos_valid,
  output logic             active_player,
  output logic             winner_valid,
  output logic             winner_id
);

  localparam int               TIMER_W    = $clog2(DONE_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DONE_TIMEOUT - 1);
  localparam logic [POS_W-1:0] START_POS  = POS_W'(START_X);

  game_state_t      state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [POS_W-1:0] p1_next, p2_next;
  logic             active_next, pos_valid_next;
  logic             winner_valid_next, winner_id_next;
  logic             finish_flag, finish_flag_next;
  logic [POS_W-1:0] cur_x, step_x;
  logic             step_reaches_finish;

  assign cur_x      = active_player ? player2_pos_x : player1_pos_x;
  assign dice_ready = (state == IDLE);

  pos_step_calc #(
    .STEP_PX  (STEP_PX),
    .FINISH_X (FINISH_X)
  ) u_step (
    .cur_x          (cur_x),
    .dice_value     (dice_value),
    .next_x         (step_x),
    .reached_finish (step_reaches_finish)
  );

  // State and game registers; active-low synchronous reset restores the initial game.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      timer         <= '0;
      player1_pos_x <= START_POS;
      player2_pos_x <= START_POS;
      active_player <= 1'b0;
      pos_valid     <= 1'b0;
      winner_valid  <= 1'b0;
      winner_id     <= 1'b0;
      finish_flag   <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      player1_pos_x <= p1_next;
      player2_pos_x <= p2_next;
      active_player <= active_next;
      pos_valid     <= pos_valid_next;
      winner_valid  <= winner_valid_next;
      winner_id     <= winner_id_next;
      finish_flag   <= finish_flag_next;
    end
  end

  // Next-state logic: accept a roll, wait for the renderer, then hand over or declare a winner.
  always_comb begin
    state_next        = state;
    timer_next        = timer;
    p1_next           = player1_pos_x;
    p2_next           = player2_pos_x;
    active_next       = active_player;
    pos_valid_next    = 1'b0;
    winner_valid_next = winner_valid;
    winner_id_next    = winner_id;
    finish_flag_next  = finish_flag;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (dice_valid && is_legal_dice(dice_value)) begin
          if (active_player) p2_next = step_x;
          else               p1_next = step_x;
          finish_flag_next = step_reaches_finish;
          pos_valid_next   = 1'b1;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        timer_next = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        timer_next = timer + 1'b1;
        if (turn_done || (timer == TIMER_LAST)) begin
          timer_next = '0;
          if (finish_flag) begin
            winner_valid_next = 1'b1;
            winner_id_next    = active_player;
            state_next        = WIN;
          end else begin
            active_next = ~active_player;
            state_next  = IDLE;
          end
        end
      end
      WIN: begin
        timer_next = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (game_restart) begin
      state_next        = IDLE;
      timer_next        = '0;
      p1_next           = START_POS;
      p2_next           = START_POS;
      active_next       = 1'b0;
      pos_valid_next    = 1'b0;
      winner_valid_next = 1'b0;
      winner_id_next    = 1'b0;
      finish_flag_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_game_turn_controller.sv
// Randomized self-checking bench for game_turn_controller against a turn-level game model.
module tb_game_turn_controller;

  localparam int START_X      = 40;
  localparam int STEP_PX      = 40;
  localparam int FINISH_X     = 560;
  localparam int DONE_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dice_valid = 1'b0;
  logic [2:0] dice_value = 3'd0;
  logic       game_restart = 1'b0;
  logic       turn_done = 1'b0;
  logic       dice_ready;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic       winner_valid;
  logic       winner_id;

  int checks = 0;
  int failures = 0;

  // Game model: positions per player, whose turn it is, and the winner if any.
  int pos[2];
  int act;
  bit won;
  int win_id;

  game_turn_controller #(
    .START_X      (START_X),
    .STEP_PX      (STEP_PX),
    .FINISH_X     (FINISH_X),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dice_valid    (dice_valid),
    .dice_value    (dice_value),
    .game_restart  (game_restart),
    .turn_done     (turn_done),
    .dice_ready    (dice_ready),
    .player1_pos_x (player1_pos_x),
    .player2_pos_x (player2_pos_x),
    .pos_valid     (pos_valid),
    .active_player (active_player),
    .winner_valid  (winner_valid),
    .winner_id     (winner_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pos[0] = START_X;
    pos[1] = START_X;
    act    = 0;
    won    = 1'b0;
    win_id = 0;
  endtask

  // Drive one cycle worth of inputs, let the edge sample them, then release all pulses.
  task automatic applyStimulus(input bit dv, input logic [2:0] dval, input bit td,
                               input bit restart, input bit rst_n);
    dice_valid   = dv;
    dice_value   = dval;
    turn_done    = td;
    game_restart = restart;
    rst          = rst_n;
    @(posedge clk);
    #1;
    dice_valid   = 1'b0;
    dice_value   = 3'd0;
    turn_done    = 1'b0;
    game_restart = 1'b0;
    rst          = 1'b1;
  endtask

  task automatic checkState(input string tag, input bit exp_pv, input bit exp_ready);
    checkOutput({tag, ".p1"},     32'(player1_pos_x), pos[0]);
    checkOutput({tag, ".p2"},     32'(player2_pos_x), pos[1]);
    checkOutput({tag, ".pv"},     32'(pos_valid),     32'(exp_pv));
    checkOutput({tag, ".ready"},  32'(dice_ready),    32'(exp_ready));
    checkOutput({tag, ".active"}, 32'(active_player), act);
    checkOutput({tag, ".wvalid"}, 32'(winner_valid),  32'(won));
    checkOutput({tag, ".wid"},    32'(winner_id),     win_id);
  endtask

  task automatic endTurn();
    if (pos[act] == FINISH_X) begin
      won    = 1'b1;
      win_id = act;
      checkState("win", 1'b0, 1'b0);
    end else begin
      act = 1 - act;
      checkState("handover", 1'b0, 1'b1);
    end
  endtask

  // mode 0: real turn_done, 1: timeout, 2: restart with turn_done, 3: reset mid-turn
  task automatic playTurn(input int d, input int mode);
    int j;
    int target;
    applyStimulus(1'b1, 3'(d), 1'b0, 1'b0, 1'b1);
    target   = pos[act] + d * STEP_PX;
    pos[act] = (target > FINISH_X) ? FINISH_X : target;
    checkState("roll", 1'b1, 1'b0);
    if (mode == 3) begin
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      modelReset();
      checkState("rst_mid", 1'b0, 1'b1);
      return;
    end
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkState("issue", 1'b0, 1'b0);
    if (mode == 1) begin
      for (int i = 0; i < DONE_TIMEOUT - 1; i++) begin
        applyStimulus(1'($urandom % 2), 3'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b1);
        checkState("wait_to", 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      endTurn();
      return;
    end
    j = $urandom_range(0, 20);
    for (int i = 0; i < j; i++) begin
      applyStimulus(1'($urandom % 2), 3'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b1);
      checkState("wait", 1'b0, 1'b0);
    end
    if (mode == 2) begin
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      modelReset();
      checkState("restart_td", 1'b0, 1'b1);
    end else begin
      applyStimulus(1'($urandom % 2), 3'($urandom_range(1, 6)), 1'b1, 1'b0, 1'b1);
      endTurn();
    end
  endtask

  initial begin
    int r;
    int mode;
    modelReset();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkState("reset", 1'b0, 1'b1);

    // First roll of 3 moves player 1 from 40 to 160.
    playTurn(3, 0);
    checkOutput("first.p1", 32'(player1_pos_x), 160);

    for (int t = 0; t < 120; t++) begin
      if (won) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b1, 3'($urandom_range(1, 6)), 1'($urandom % 2), 1'b0, 1'b1);
          checkState("win_hold", 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        modelReset();
        checkState("restart", 1'b0, 1'b1);
      end else begin
        if ($urandom % 4 == 0) begin
          applyStimulus(1'b1, (($urandom % 2) == 0) ? 3'd0 : 3'd7, 1'b0, 1'b0, 1'b1);
          checkState("illegal", 1'b0, 1'b1);
        end
        if ($urandom % 6 == 0) begin
          applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
          checkState("stray_td", 1'b0, 1'b1);
        end
        r = int'($urandom % 20);
        if (r < 16)      mode = 0;
        else if (r < 18) mode = 1;
        else if (r < 19) mode = 2;
        else             mode = 3;
        playTurn(int'($urandom_range(1, 6)), mode);
      end
    end

    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    modelReset();
    checkState("restart2", 1'b0, 1'b1);
    playTurn(2, 1);
    playTurn(4, 2);
    playTurn(5, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
